apc_add_ctrl: RTL and testbench
===============================

Name: apc_add_ctrl

Overview:
- Window sequencer for the approximate parallel counter adder (apcADD) in stochastic-computing datapaths.
- On `start`, runs the adder for a programmed number of bitstream cycles and drives its select input (`randNum`) each cycle.
- Enables upstream bitstream generators while the window is open and counts ones on the adder's scaled output bit.
- Returns the binary count with a one-cycle `done` pulse. Sits between the system scheduler and an apcADD instance.

Parameters:
- INUM, 8: number of adder input bitstreams (must match apcADD).
- LOGINUM, 3: log2(INUM); width of `randNum`.
- CWIDTH, 8: width of window length and result count; maximum window is 2^CWIDTH-1 cycles.
- LAT, 1: apcADD input-to-output latency in cycles; legal range 0..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a new window; sampled in IDLE or DONE only.
- abort  in  1  cancel the window in progress.
- win_len  in  CWIDTH  window length in cycles; latched on an accepted start.
- src_en  out  1  enables upstream bitstream generators and apcADD input issue.
- randNum  out  LOGINUM  select/scaling number to apcADD.
- apc_out  in  1  apcADD output bit.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the result is valid.
- count  out  CWIDTH  ones counted over the last completed window; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; src_en=0, randNum=0, busy=0, done=0, count=0; the issue pipeline is cleared. Reset mid-window discards everything.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with start=1, win_len!=0:
  - Latch win_len, clear count and the issue counter, go to RUN.
  - A start sampled in the DONE cycle is accepted, so back-to-back windows are allowed.
- IDLE/DONE with start=1, win_len=0: go to DONE next cycle with count=0, done=1.
- DONE always lasts one cycle, then IDLE unless a start is accepted.
- start while busy is ignored; no queuing.
- RUN:
  - src_en=1, busy=1; one issue per cycle, exactly win_len cycles.
  - After the last issue cycle, go to DRAIN if LAT>0, else go to DONE.
- DRAIN: src_en=0, busy=1, randNum holds its last value; lasts exactly LAT cycles, then DONE.
- Timing: start accepted at edge t gives RUN cycles t+1..t+W, DRAIN t+W+1..t+W+LAT, done high at t+W+LAT+1.
- Sampling:
  - Each issue cycle pushes a valid bit into an LAT-deep shift register.
  - apc_out is counted when the delayed valid=1 and apc_out=1.
  - apc_out is ignored otherwise, including in IDLE and DONE.
- count saturates at 2^CWIDTH-1. It cannot overflow for legal win_len; saturation is a guard only.
- randNum (default):
  - Modulo-2^LOGINUM counter, 0 in the first RUN cycle, incrementing each RUN cycle.
  - Wraps 2^LOGINUM-1 -> 0.
  - Restarts at 0 on every accepted start.
- abort:
  - In RUN or DRAIN: next state IDLE, src_en=0, busy=0, count=0, pipeline cleared, no done.
  - In IDLE or DONE: no effect.
  - abort and start in the same cycle: abort wins only if busy; otherwise start is processed.
- done and busy are never high together.

Optional Feature:
- Macro: APC_ADD_CTRL_LFSR_EN.
- Defined: randNum comes from a LOGINUM-bit maximal-length Fibonacci LFSR instead of the counter.
  - Seed is 1, reloaded on every accepted start; it advances each RUN cycle.
  - The LFSR never outputs 0; the sequence period is 2^LOGINUM-1.
  - Supported LOGINUM 2..8 via a tap table.
- Not defined: counter behaviour as above; no LFSR logic synthesised.

Decomposition:
- Package apc_add_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - LFSR tap table indexed by LOGINUM;
  - default INUM/LOGINUM/CWIDTH constants shared with apcADD.
- One sub-module, apc_rand_gen:
  - counter or LFSR selected by APC_ADD_CTRL_LFSR_EN;
  - inputs: load, advance;
  - output: randNum.
- Controller FSM, issue pipeline and counter stay in apc_add_ctrl.

Test Plan:
- Common bench setup: INUM=8, LOGINUM=3, CWIDTH=8, LAT=1, real apcADD instance driven by the controller.
1. apc_out forced 1, win_len=16, start at edge 0 -> src_en high edges 1..16, busy edges 1..17, done at edge 18, count=16. Default build: randNum = 0..7,0..7.
2. apc_out forced 0, win_len=200 -> done at edge 202, count=0. Then apcADD in=8'hFF -> count=200. Then in=8'h01, win_len=8, counter randNum -> count=1.
3. win_len=0 start -> no src_en; done next cycle with count=0; busy never high.
4. win_len=20, abort at RUN cycle 7 -> IDLE next cycle, count=0, no done. A start in the same cycle as the abort is ignored. A fresh start afterwards completes normally.
5. Back-to-back: start held high through the DONE cycle with win_len=4 -> second window RUN begins the cycle after done; count clears at acceptance; randNum restarts at 0. A rst_n pulse mid-RUN zeroes all outputs at the next edge.
6. LFSR build (APC_ADD_CTRL_LFSR_EN defined), win_len=14 -> randNum never 0, period-7 sequence starting at seed 1 and repeated twice. Result count matches a bench reference model.

Source files
------------

// File: rtl/apc_add_pkg.sv
// Shared types and constants for the apcADD window sequencer and its select generator.
// The tap table is only consumed when APC_ADD_CTRL_LFSR_EN is defined.
package apc_add_pkg;

    localparam int APC_INUM    = 8;
    localparam int APC_LOGINUM = 3;
    localparam int APC_CWIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } apc_state_e;

    // Maximal-length Fibonacci taps; bit i set means register bit i feeds the XOR.
    function automatic logic [7:0] lfsr_taps(input int n);
        logic [7:0] t;
        case (n)
            2:       t = 8'b0000_0011;
            3:       t = 8'b0000_0110;
            4:       t = 8'b0000_1100;
            5:       t = 8'b0001_0100;
            6:       t = 8'b0011_0000;
            7:       t = 8'b0110_0000;
            8:       t = 8'b1011_1000;
            default: t = 8'b0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/apc_add_ctrl_rand_gen.sv
// Select-number generator for apcADD: a modulo counter by default, or a Fibonacci
// LFSR (seed 1, never zero) when APC_ADD_CTRL_LFSR_EN is defined.
module apc_rand_gen
    import apc_add_pkg::*;
#(
    parameter int LOGINUM = APC_LOGINUM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               advance,
    output logic [LOGINUM-1:0] randNum
);

    logic [LOGINUM-1:0] rnd_q, rnd_d;

`ifdef APC_ADD_CTRL_LFSR_EN
    if (LOGINUM < 2 || LOGINUM > 8) begin : g_bad_width
        $error("apc_rand_gen: LFSR supports LOGINUM 2..8");
    end

    localparam logic [LOGINUM-1:0] TAPS = LOGINUM'(lfsr_taps(LOGINUM));

    always_comb begin
        rnd_d = rnd_q;
        if (load) begin
            rnd_d = LOGINUM'(1);
        end else if (advance) begin
            rnd_d = {rnd_q[LOGINUM-2:0], ^(rnd_q & TAPS)};
        end
    end
`else
    always_comb begin
        rnd_d = rnd_q;
        if (load) begin
            rnd_d = '0;
        end else if (advance) begin
            rnd_d = rnd_q + LOGINUM'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rnd_q <= '0;
        end else begin
            rnd_q <= rnd_d;
        end
    end

    assign randNum = rnd_q;

endmodule

// File: rtl/apc_add_ctrl.sv
// Window sequencer for the approximate parallel counter adder: issues win_len cycles,
// drains LAT cycles of adder latency and counts ones. Build option: APC_ADD_CTRL_LFSR_EN.
module apc_add_ctrl
    import apc_add_pkg::*;
#(
    parameter int INUM    = APC_INUM,
    parameter int LOGINUM = APC_LOGINUM,
    parameter int CWIDTH  = APC_CWIDTH,
    parameter int LAT     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CWIDTH-1:0]  win_len,
    output logic               src_en,
    output logic [LOGINUM-1:0] randNum,
    input  logic               apc_out,
    output logic               busy,
    output logic               done,
    output logic [CWIDTH-1:0]  count
);

    if (INUM != (1 << LOGINUM)) begin : g_bad_inum
        $error("apc_add_ctrl: INUM must equal 2**LOGINUM");
    end
    if (LAT < 0 || LAT > 4) begin : g_bad_lat
        $error("apc_add_ctrl: LAT must be 0..4");
    end

    apc_state_e        state_q, state_d;
    logic [CWIDTH-1:0] len_q, len_d;
    logic [CWIDTH-1:0] issue_q, issue_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic [2:0]        drain_q, drain_d;

    logic issue, last_issue, accept, kill, smp_vld, adv;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issue_d    = issue_q;
        count_d    = count_q;
        drain_d    = drain_q;
        accept     = 1'b0;
        kill       = 1'b0;
        issue      = (state_q == ST_RUN);
        last_issue = issue && (issue_q == len_q - CWIDTH'(1));

        // Counting goes first so an accepted start or an abort below overrides it.
        if (smp_vld && apc_out && (count_q != '1)) begin
            count_d = count_q + CWIDTH'(1);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    accept  = 1'b1;
                    len_d   = win_len;
                    issue_d = '0;
                    count_d = '0;
                    drain_d = '0;
                    state_d = (win_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                issue_d = issue_q + CWIDTH'(1);
                if (last_issue) begin
                    state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == 3'(LAT - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
            kill    = 1'b1;
            state_d = ST_IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            issue_q <= '0;
            count_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            count_q <= count_d;
            drain_q <= drain_d;
        end
    end

    // Valid bits follow each issue through the adder latency to qualify apc_out.
    if (LAT == 0) begin : g_lat0
        assign smp_vld = issue;
    end else begin : g_lat
        logic [LAT-1:0] vld_pipe_q, vld_pipe_d;

        always_comb begin
            vld_pipe_d = kill ? '0 : ((vld_pipe_q << 1) | LAT'(issue));
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_pipe_q <= '0;
            end else begin
                vld_pipe_q <= vld_pipe_d;
            end
        end

        assign smp_vld = vld_pipe_q[LAT-1];
    end

    // The select stays on the last issued value through DRAIN.
    assign adv = issue && !last_issue;

    apc_rand_gen #(
        .LOGINUM (LOGINUM)
    ) u_rand (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .advance (adv),
        .randNum (randNum)
    );

    assign src_en = (state_q == ST_RUN);
    assign busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done   = (state_q == ST_DONE);
    assign count  = count_q;

endmodule

// File: tb/tb_apc_add_ctrl.sv
// Directed bench for apc_add_ctrl with a behavioural mux-style apcADD (LAT=1).
// Follows APC_ADD_CTRL_LFSR_EN for the expected select sequence.
module tb_apc_add_ctrl;

    localparam int INUM    = 8;
    localparam int LOGINUM = 3;
    localparam int CWIDTH  = 8;
    localparam int LAT     = 1;

    localparam int LFSR_SEQ [7] = '{1, 2, 5, 3, 7, 6, 4};

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [CWIDTH-1:0]  win_len;
    logic               src_en;
    logic [LOGINUM-1:0] randNum;
    logic               apc_out;
    logic               busy;
    logic               done;
    logic [CWIDTH-1:0]  count;

    logic [INUM-1:0] add_in;
    logic            frc_en, frc_val, apc_q;

    int n_vec = 0;
    int n_err = 0;

    apc_add_ctrl #(
        .INUM    (INUM),
        .LOGINUM (LOGINUM),
        .CWIDTH  (CWIDTH),
        .LAT     (LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .win_len (win_len),
        .src_en  (src_en),
        .randNum (randNum),
        .apc_out (apc_out),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scaled adder: one-cycle registered mux of the input picked by randNum.
    always @(posedge clk) apc_q <= src_en & add_in[randNum];
    assign apc_out = frc_en ? frc_val : apc_q;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_rand(input int k);
`ifdef APC_ADD_CTRL_LFSR_EN
        return LFSR_SEQ[k % 7];
`else
        return k % 8;
`endif
    endfunction

    function automatic int ref_cnt(input logic [INUM-1:0] in, input int len);
        int s = 0;
        for (int k = 0; k < len; k++) s += int'(in[exp_rand(k)]);
        return s;
    endfunction

    task automatic fire(input int len);
        @(negedge clk);
        win_len = CWIDTH'(len);
        start   = 1'b1;
    endtask

    // Start a window, then expect done exactly LAT+1 cycles after the last issue.
    task automatic run_window(input string tag, input int len, input int exp_cnt);
        int j;
        int lim;
        fire(len);
        lim = len + LAT + 8;
        j = 0;
        while (j < lim) begin
            @(negedge clk);
            j++;
            if (j == 1) start = 1'b0;
            if (done) break;
        end
        chk({tag, "_done_at"}, done ? j : -1, len + LAT + 1);
        chk({tag, "_count"}, int'(count), exp_cnt);
        @(negedge clk);
        chk({tag, "_done_drop"}, int'(done), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        win_len = '0;
        add_in  = '0;
        frc_en  = 1'b1;
        frc_val = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_src_en", int'(src_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_rand", int'(randNum), 0);
        rst_n = 1'b1;

        // 1: all-ones stream, 16-cycle window, cycle-by-cycle shape
        frc_val = 1'b1;
        fire(16);
        for (int j = 1; j <= 19; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            chk($sformatf("t1_src_e%0d", j), int'(src_en), int'(j <= 16));
            chk($sformatf("t1_busy_e%0d", j), int'(busy), int'(j <= 17));
            chk($sformatf("t1_done_e%0d", j), int'(done), int'(j == 18));
            if (j <= 16) chk($sformatf("t1_rand_e%0d", j), int'(randNum), exp_rand(j - 1));
            if (j == 17) chk("t1_rand_drain", int'(randNum), exp_rand(15));
            if (j == 18) chk("t1_count", int'(count), 16);
        end

        // 2: zero stream, long window, then real adder inputs
        frc_val = 1'b0;
        run_window("t2_zero", 200, 0);
        frc_en = 1'b0;
        add_in = 8'hFF;
        run_window("t2_ff", 200, 200);
        add_in = 8'h01;
        run_window("t2_01", 8, ref_cnt(8'h01, 8));

        // 3: zero-length window
        fire(0);
        @(negedge clk);
        start = 1'b0;
        chk("t3_done", int'(done), 1);
        chk("t3_count", int'(count), 0);
        chk("t3_busy", int'(busy), 0);
        chk("t3_src_en", int'(src_en), 0);
        @(negedge clk);
        chk("t3_done_drop", int'(done), 0);
        chk("t3_busy_after", int'(busy), 0);

        // 4: abort at RUN cycle 7, with a colliding start
        frc_en  = 1'b1;
        frc_val = 1'b1;
        fire(20);
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
        end
        chk("t4_count_pre", int'(count), 5);
        abort   = 1'b1;
        start   = 1'b1;
        win_len = 8'd3;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("t4_busy", int'(busy), 0);
        chk("t4_src_en", int'(src_en), 0);
        chk("t4_count", int'(count), 0);
        chk("t4_done", int'(done), 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("t4_idle_busy%0d", j), int'(busy), 0);
            chk($sformatf("t4_idle_done%0d", j), int'(done), 0);
        end
        run_window("t4_fresh", 5, 5);

        // 5: back-to-back windows with start held through DONE, then reset mid-RUN
        fire(4);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 6) begin
                chk("t5_done1", int'(done), 1);
                chk("t5_count1", int'(count), 4);
            end
            if (j == 7) begin
                start = 1'b0;
                chk("t5_src2", int'(src_en), 1);
                chk("t5_done_busy", int'(done), 0);
                chk("t5_count_clr", int'(count), 0);
                chk("t5_rand_rst", int'(randNum), exp_rand(0));
            end
            if (j == 11) chk("t5_nodone11", int'(done), 0);
            if (j == 12) begin
                chk("t5_done2", int'(done), 1);
                chk("t5_count2", int'(count), 4);
            end
        end
        fire(10);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
        end
        chk("t5_pre_rst_count", int'(count), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_rst_src", int'(src_en), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_done", int'(done), 0);
        chk("t5_rst_count", int'(count), 0);
        chk("t5_rst_rand", int'(randNum), 0);
        @(negedge clk);
        chk("t5_post_rst_busy", int'(busy), 0);

        // 6: select sequence over 14 cycles, count against the reference model
        frc_en = 1'b0;
        add_in = 8'b1010_0110;
        fire(14);
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            chk($sformatf("t6_rand_e%0d", j), int'(randNum), exp_rand(j - 1));
`ifdef APC_ADD_CTRL_LFSR_EN
            chk($sformatf("t6_nz_e%0d", j), int'(randNum != 0), 1);
`endif
        end
        begin
            int j = 14;
            while (!done && j < 30) begin
                @(negedge clk);
                j++;
            end
            chk("t6_done_at", done ? j : -1, 14 + LAT + 1);
            chk("t6_count", int'(count), ref_cnt(8'b1010_0110, 14));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
